// File: rtl/popcount_frame_accumulator.sv
// Sums per-word ones counts over a frame and holds the frame total, word count and max
// in a single-entry valid/ready output register. Optional threshold flag: POPACC_THRESH_EN.
module popcount_frame_accumulator #(
  parameter int FRAME_LEN = 16,
  parameter int ACC_W     = 9,
  parameter int WCNT_W    = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_count,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_total,
  output logic [WCNT_W-1:0] out_words,
  output logic [4:0]        out_max
`ifdef POPACC_THRESH_EN
  ,
  input  logic [ACC_W-1:0]  thresh,
  output logic              out_over
`endif
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  function automatic logic [4:0] clamp16(input logic [4:0] c);
    return (c > 5'd16) ? 5'd16 : c;
  endfunction

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a, input logic [4:0] b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {{(ACC_W-4){1'b0}}, b};
    return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
  endfunction

  state_t              state_q;
  logic [ACC_W-1:0]    sum_q, out_total_q;
  logic [WCNT_W-1:0]   wcnt_q, out_words_q;
  logic [4:0]          max_q, out_max_q;
  logic                out_valid_q, in_ready_q;

  logic                accept;
  logic                closing;
  logic [4:0]          cnt_c;
  logic [ACC_W-1:0]    sum_d;
  logic [WCNT_W-1:0]   wcnt_d;
  logic [4:0]          max_d;

  assign accept  = in_valid && in_ready_q;
  assign cnt_c   = clamp16(in_count);
  assign sum_d   = sat_add(sum_q, cnt_c);
  assign wcnt_d  = wcnt_q + WCNT_W'(1);
  assign max_d   = (cnt_c > max_q) ? cnt_c : max_q;
  // wcnt_q counts beats already taken, so FRAME_LEN=1 closes on every beat
  assign closing = in_last || (wcnt_q == WCNT_W'(FRAME_LEN - 1));

`ifdef POPACC_THRESH_EN
  logic out_over_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_over_q <= 1'b0;
    end else if (accept && closing) begin
      out_over_q <= (sum_d > thresh);
    end
  end
  assign out_over = out_over_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      wcnt_q      <= '0;
      max_q       <= '0;
      out_total_q <= '0;
      out_words_q <= '0;
      out_max_q   <= '0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (accept && closing) begin
            state_q     <= DONE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
            out_total_q <= sum_d;
            out_words_q <= wcnt_d;
            out_max_q   <= max_d;
            sum_q       <= '0;
            wcnt_q      <= '0;
            max_q       <= '0;
          end else begin
            in_ready_q <= 1'b1;
            if (accept) begin
              state_q <= ACCUM;
              sum_q   <= sum_d;
              wcnt_q  <= wcnt_d;
              max_q   <= max_d;
            end
          end
        end
        DONE: begin
          // in_ready stays low here, so a held source beat waits for the next edge
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_total = out_total_q;
  assign out_words = out_words_q;
  assign out_max   = out_max_q;

endmodule

// File: tb/tb_popcount_frame_accumulator.sv
// Bench for popcount_frame_accumulator: vector table, directed corner sequences and
// randomized traffic against a frame-level reference model.
module tb_popcount_frame_accumulator;

  localparam int FRAME_LEN = 16;
  localparam int ACC_W     = 9;
  localparam int WCNT_W    = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [4:0]        in_count = '0;
  logic              in_last = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [ACC_W-1:0]  out_total;
  logic [WCNT_W-1:0] out_words;
  logic [4:0]        out_max;
`ifdef POPACC_THRESH_EN
  logic [ACC_W-1:0]  thresh = '0;
  logic              out_over;
`endif

  popcount_frame_accumulator #(
    .FRAME_LEN(FRAME_LEN), .ACC_W(ACC_W), .WCNT_W(WCNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_count(in_count), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_total(out_total), .out_words(out_words), .out_max(out_max)
`ifdef POPACC_THRESH_EN
    , .thresh(thresh), .out_over(out_over)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: frame contents kept as a list, results computed from the list
  int m_q[$];
  bit m_started, m_pending;
  int m_total, m_words, m_max;
  bit m_over;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_started = 0; m_pending = 0;
    m_total = 0; m_words = 0; m_max = 0; m_over = 0;
  endtask

  task automatic model_edge();
    bit rdy;
    int c, s, mx;
    rdy = m_started && !m_pending;
    if (m_pending && out_ready) begin
      m_pending = 0;
    end else if (in_valid && rdy) begin
      c = (int'(in_count) > 16) ? 16 : int'(in_count);
      m_q.push_back(c);
      if (in_last || m_q.size() == FRAME_LEN) begin
        s = 0; mx = 0;
        foreach (m_q[i]) begin
          s += m_q[i];
          if (m_q[i] > mx) mx = m_q[i];
        end
        if (s > (1 << ACC_W) - 1) s = (1 << ACC_W) - 1;
        m_total = s; m_words = m_q.size(); m_max = mx;
`ifdef POPACC_THRESH_EN
        m_over = (s > int'(thresh));
`endif
        m_pending = 1;
        m_q.delete();
      end
    end
    m_started = 1;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_in_ready"},  int'(in_ready),  int'(m_started && !m_pending));
    chk({tag, "_out_valid"}, int'(out_valid), int'(m_pending));
    chk({tag, "_total"},     int'(out_total), m_total);
    chk({tag, "_words"},     int'(out_words), m_words);
    chk({tag, "_max"},       int'(out_max),   m_max);
`ifdef POPACC_THRESH_EN
    chk({tag, "_over"},      int'(out_over),  int'(m_over));
`endif
  endtask

  // One clock: model follows the edge, outputs compared 1 time unit later
  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_clear();
    chk("rst_in_ready",  int'(in_ready),  0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_total",     int'(out_total), 0);
    chk("rst_words",     int'(out_words), 0);
    chk("rst_max",       int'(out_max),   0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic beat(input int c, input bit last, input string tag);
    in_valid = 1'b1; in_count = 5'(c); in_last = last;
    tick(tag);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  typedef struct {
    int n;
    int c[4];
    int e_total;
    int e_words;
    int e_max;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int vcnt;
    int hold_total;

    vecs[0] = '{n: 3, c: '{3, 7, 1, 0},     e_total: 11, e_words: 3, e_max: 7};
    vecs[1] = '{n: 2, c: '{31, 2, 0, 0},    e_total: 18, e_words: 2, e_max: 16};
    vecs[2] = '{n: 1, c: '{0, 0, 0, 0},     e_total: 0,  e_words: 1, e_max: 0};
    vecs[3] = '{n: 4, c: '{5, 5, 5, 4},     e_total: 19, e_words: 4, e_max: 5};
    vecs[4] = '{n: 2, c: '{16, 16, 0, 0},   e_total: 32, e_words: 2, e_max: 16};
    vecs[5] = '{n: 3, c: '{17, 9, 20, 0},   e_total: 41, e_words: 3, e_max: 16};

    do_reset();
    tick("idle");

    // Full frame of 16 maximal words, consumer always ready
    out_ready = 1'b1;
    vcnt = 0;
    for (int i = 0; i < FRAME_LEN; i++) begin
      beat(16, 1'b0, "t1");
      if (out_valid) vcnt++;
    end
    chk("t1_total", int'(out_total), 256);
    chk("t1_words", int'(out_words), 16);
    chk("t1_max",   int'(out_max),   16);
    for (int i = 0; i < 4; i++) begin
      tick("t1_drain");
      if (out_valid) vcnt++;
    end
    chk("t1_valid_cycles", vcnt, 1);

    // Table of frames closed with in_last
    for (int v = 0; v < 6; v++) begin
      out_ready = 1'b0;
      for (int b = 0; b < vecs[v].n; b++)
        beat(vecs[v].c[b], b == vecs[v].n - 1, "tab");
      chk("tab_valid", int'(out_valid), 1);
      chk("tab_total", int'(out_total), vecs[v].e_total);
      chk("tab_words", int'(out_words), vecs[v].e_words);
      chk("tab_max",   int'(out_max),   vecs[v].e_max);
      out_ready = 1'b1;
      tick("tab_drain");
    end

    // Backpressure: result held 5 cycles while the source holds a beat
    out_ready = 1'b0;
    beat(4, 1'b0, "t3");
    beat(9, 1'b1, "t3");
    hold_total = int'(out_total);
    chk("t3_total", hold_total, 13);
    in_valid = 1'b1; in_count = 5'd5; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick("t3_hold");
      chk("t3_ready_low", int'(in_ready), 0);
      chk("t3_stable", int'(out_total), hold_total);
    end
    out_ready = 1'b1;
    tick("t3_release");
    chk("t3_ready_back", int'(in_ready), 1);
    tick("t3_next");
    in_valid = 1'b0; in_last = 1'b0;
    chk("t3_next_total", int'(out_total), 5);
    chk("t3_next_words", int'(out_words), 1);
    tick("t3_drain");

    // Reset in the middle of a frame discards it
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) beat(10, 1'b0, "t5");
    do_reset();
    tick("t5_idle");
    chk("t5_no_valid", int'(out_valid), 0);
    beat(2, 1'b0, "t5");
    beat(3, 1'b1, "t5");
    chk("t5_total", int'(out_total), 5);
    chk("t5_words", int'(out_words), 2);
    out_ready = 1'b1;
    tick("t5_drain");

    // Reset while a result is pending
    out_ready = 1'b0;
    beat(7, 1'b1, "t5b");
    do_reset();
    tick("t5b_idle");
    chk("t5b_no_valid", int'(out_valid), 0);

`ifdef POPACC_THRESH_EN
    thresh = 9'd100;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) beat(16, 1'b0, "t6a");
    beat(4, 1'b1, "t6a");
    chk("t6a_total", int'(out_total), 100);
    chk("t6a_over",  int'(out_over), 0);
    tick("t6a_drain");
    for (int i = 0; i < 6; i++) beat(16, 1'b0, "t6b");
    beat(5, 1'b1, "t6b");
    chk("t6b_total", int'(out_total), 101);
    chk("t6b_over",  int'(out_over), 1);
    tick("t6b_drain");
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_count  = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(17, 31)) : 5'($urandom_range(0, 16));
      in_last   = ($urandom_range(0, 9) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
`ifdef POPACC_THRESH_EN
      thresh    = 9'($urandom_range(0, 300));
`endif
      tick("rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
